// File: rtl/wb_project_mux.sv
// Arbitrates NPROJ user projects onto one set of pads and one wishbone slave port, selected by a control register.
// Latency: control register acks one cycle after the request, selected-project data passes through with zero latency.
// Backpressure: host holds stb until ack; a silent project is acked by a watchdog, and strobes to it are gated until stb drops.
module wb_project_mux #(
  parameter int          NPROJ     = 16,
  parameter int          IO_W      = 38,
  parameter int          GUARD     = 4,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] CTRL_ADDR = 32'h3000_FFFC
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic [NPROJ-1:0]      active_o,
  output logic [NPROJ-1:0]      proj_stb_o,
  input  logic [NPROJ-1:0]      proj_ack_i,
  input  logic [NPROJ*32-1:0]   proj_dat_i,
  input  logic [NPROJ*IO_W-1:0] proj_io_out_i,
  input  logic [NPROJ*IO_W-1:0] proj_io_oeb_i,
  output logic [IO_W-1:0]       io_out,
  output logic [IO_W-1:0]       io_oeb
);

  localparam logic [31:0] ERR_DAT = 32'hDEAD_BEEF;
  localparam logic [7:0]  NONE    = 8'hFF;
  localparam logic [8:0]  NPROJ_W = 9'(NPROJ);
  localparam int          GC_W    = $clog2(GUARD + 1);
  localparam int          WD_W    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_ENABLE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cur_sel_q, cur_sel_d;
  logic [7:0]        tgt_q, tgt_d;
  logic [GC_W-1:0]   gcnt_q, gcnt_d;
  logic [WD_W-1:0]   wd_cnt_q;
  logic              gate_q;
  logic              ctrl_ack_q;
  logic [31:0]       ctrl_rdat_q;
  logic              err_ack_q;
  logic              err_q;
  logic              timeout_q;

  logic              bus_req;
  logic              ctrl_hit;
  logic              ctrl_acc;
  logic              ctrl_wr;
  logic              clr_wr;
  logic              sel_wr;
  logic              tgt_bad;
  logic [7:0]        wr_tgt;
  logic              switch_req;
  logic              sel_ok;
  logic              data_req;
  logic              routed;
  logic              unrouted;
  logic              sel_ack;
  logic [31:0]       sel_dat;
  logic              wd_fire;
  logic              unused_ok;

  // Byte selects and the unused write-data bits carry no meaning for this block.
  assign unused_ok = ^{wbs_sel_i, wbs_dat_i[30:8]};

  assign bus_req  = wbs_stb_i & wbs_cyc_i;
  assign ctrl_hit = bus_req & (wbs_adr_i == CTRL_ADDR);
  // A held strobe during the ack cycle must not be taken as a second access.
  assign ctrl_acc = ctrl_hit & ~ctrl_ack_q;
  assign ctrl_wr  = ctrl_acc & wbs_we_i;
  assign clr_wr   = ctrl_wr & wbs_dat_i[31];
  assign sel_wr   = ctrl_wr & ~wbs_dat_i[31];

  // Out-of-range targets collapse to "none" so cur_sel is always a valid index or NONE.
  assign tgt_bad    = ({1'b0, wbs_dat_i[7:0]} >= NPROJ_W) && (wbs_dat_i[7:0] != NONE);
  assign wr_tgt     = ({1'b0, wbs_dat_i[7:0]} < NPROJ_W) ? wbs_dat_i[7:0] : NONE;
  assign switch_req = sel_wr && (wr_tgt != cur_sel_q);

  assign sel_ok   = (state_q == ST_RUN) && ({1'b0, cur_sel_q} < NPROJ_W);
  assign data_req = bus_req & (wbs_adr_i != CTRL_ADDR);
  assign routed   = data_req & sel_ok & ~gate_q;
  assign unrouted = data_req & ~sel_ok & ~err_ack_q;

  // The project's own ack wins over the watchdog when both land on the same cycle.
  assign wd_fire  = routed && (wd_cnt_q == WD_W'(TIMEOUT)) && !sel_ack;

  // Select the owning project's ack, data and pads; no owner leaves the pads tri-stated.
  always_comb begin
    active_o = '0;
    sel_ack  = 1'b0;
    sel_dat  = '0;
    io_out   = '0;
    io_oeb   = '1;
    for (int k = 0; k < NPROJ; k++) begin
      if (sel_ok && (cur_sel_q == 8'(k))) begin
        active_o[k] = 1'b1;
        sel_ack     = proj_ack_i[k];
        sel_dat     = proj_dat_i[k*32 +: 32];
        io_out      = proj_io_out_i[k*IO_W +: IO_W];
        io_oeb      = proj_io_oeb_i[k*IO_W +: IO_W];
      end
    end
  end

  assign proj_stb_o = active_o & {NPROJ{routed}};

  // Host ack/data: control response, error/watchdog response, or project passthrough.
  always_comb begin
    wbs_ack_o = ctrl_ack_q | err_ack_q | wd_fire | (routed & sel_ack);
    wbs_dat_o = '0;
    if (ctrl_ack_q) begin
      wbs_dat_o = ctrl_rdat_q;
    end else if (err_ack_q || wd_fire) begin
      wbs_dat_o = ERR_DAT;
    end else if (routed) begin
      wbs_dat_o = sel_dat;
    end
  end

  // Switch FSM next state: drain for GUARD cycles, commit the target for one cycle, then run.
  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    tgt_d     = tgt_q;
    gcnt_d    = gcnt_q;
    case (state_q)
      ST_DRAIN: begin
        if (gcnt_q == GC_W'(GUARD - 1)) begin
          state_d = ST_ENABLE;
        end else begin
          gcnt_d = gcnt_q + GC_W'(1);
        end
      end
      ST_ENABLE: begin
        cur_sel_d = tgt_q;
        state_d   = ST_RUN;
      end
      default: ;
    endcase
    // A new target from any state (re)starts a full drain.
    if (switch_req) begin
      state_d = ST_DRAIN;
      tgt_d   = wr_tgt;
      gcnt_d  = '0;
    end
  end

  // Switch FSM state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= ST_RUN;
      cur_sel_q <= NONE;
      tgt_q     <= NONE;
      gcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      tgt_q     <= tgt_d;
      gcnt_q    <= gcnt_d;
    end
  end

  // Control register responses, error acks and sticky flags.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ctrl_ack_q  <= 1'b0;
      ctrl_rdat_q <= '0;
      err_ack_q   <= 1'b0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      ctrl_ack_q <= ctrl_acc;
      err_ack_q  <= unrouted;
      if (ctrl_acc) begin
        ctrl_rdat_q <= {timeout_q, err_q, 2'(state_q), 20'b0, cur_sel_q};
      end
      if (clr_wr) begin
        err_q     <= 1'b0;
        timeout_q <= 1'b0;
      end else begin
        if (sel_wr && tgt_bad) err_q <= 1'b1;
        if (wd_fire)           timeout_q <= 1'b1;
      end
    end
  end

  // Watchdog: count unacked cycles of a routed request; after firing, gate strobes until stb drops.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wd_cnt_q <= '0;
      gate_q   <= 1'b0;
    end else begin
      if (!routed || sel_ack || wd_fire) begin
        wd_cnt_q <= '0;
      end else begin
        wd_cnt_q <= wd_cnt_q + WD_W'(1);
      end
      if (!wbs_stb_i) begin
        gate_q <= 1'b0;
      end else if (wd_fire) begin
        gate_q <= 1'b1;
      end
    end
  end

endmodule
